// File: rtl/uart_pkg.sv
// Shared UART definitions: frame configuration used by both rx_control and tx_control,
// plus the receive state encoding.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef struct packed {
    logic [3:0] data_len;   // 5..9
    logic       parity_en;
    logic       parity_odd;
    logic       stop2;
  } control_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP0,
    RX_STOP1,
    RX_BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input; the reset value is a
// parameter so idle-high lines (RXD, CTS) come out of reset inactive.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rx_control.sv
// UART receiver: oversampled start detection, mid-bit sampling of data/parity/stop,
// and a single-entry valid/ready output register with sticky overrun.
module rx_control
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int MAX_DATA   = MAX_DATA_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  control_t            control,
  input  logic                baud_tick,
  input  logic                rxd,
  input  logic                rdy,
  output logic                vld,
  output logic [MAX_DATA-1:0] data,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun
);

  localparam int            TW   = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TOP  = TW'(OVERSAMPLE - 1);

  logic rxs;
  logic rxs_prev_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_rxd_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rxd),
    .q       (rxs)
  );

  rx_state_t           state_q, state_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [3:0]          bcnt_q, bcnt_d;
  logic [MAX_DATA-1:0] shreg_q, shreg_d;
  control_t            frame_q, frame_d;
  logic                perr_q, perr_d;
  logic                mid_sample;
  logic                deliver;

  logic                vld_q;
  logic [MAX_DATA-1:0] data_q;
  logic                perr_out_q;
  logic                ferr_out_q;
  logic                ovr_q;

  assign mid_sample = baud_tick && (tcnt_q == MID);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    frame_d = frame_q;
    perr_d  = perr_q;
    deliver = 1'b0;

    if (baud_tick) begin
      tcnt_d = (tcnt_q == TOP) ? '0 : tcnt_q + 1'b1;
    end

    case (state_q)
      RX_IDLE: begin
        if (rxs_prev_q && !rxs) begin
          tcnt_d  = '0;
          frame_d = control;
          state_d = RX_START;
        end
      end
      RX_START: begin
        // tcnt keeps running through the mid-point so the next tcnt==MID is one full bit later
        if (mid_sample) begin
          if (rxs) begin
            state_d = RX_IDLE;
          end else begin
            bcnt_d  = '0;
            shreg_d = '0;
            perr_d  = 1'b0;
            state_d = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (mid_sample) begin
          for (int i = 0; i < MAX_DATA; i++) begin
            if (bcnt_q == 4'(i)) shreg_d[i] = rxs;
          end
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == frame_q.data_len - 4'd1) begin
            state_d = frame_q.parity_en ? RX_PARITY : RX_STOP0;
          end
        end
      end
      RX_PARITY: begin
        if (mid_sample) begin
          perr_d  = (^shreg_q) ^ rxs ^ frame_q.parity_odd;
          state_d = RX_STOP0;
        end
      end
      RX_STOP0: begin
        if (mid_sample) begin
          deliver = 1'b1;
          if (frame_q.stop2)  state_d = RX_STOP1;
          else if (!rxs)      state_d = RX_BREAK;
          else                state_d = RX_IDLE;
        end
      end
      RX_STOP1: begin
        if (mid_sample) begin
          state_d = rxs ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (rxs) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RX_IDLE;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      shreg_q    <= '0;
      frame_q    <= '0;
      perr_q     <= 1'b0;
      rxs_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      frame_q    <= frame_d;
      perr_q     <= perr_d;
      rxs_prev_q <= rxs;
    end
  end

  // A delivery while the consumer is stalled drops the new word and flags overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q      <= 1'b0;
      data_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (deliver) begin
        if (!vld_q || rdy) begin
          vld_q      <= 1'b1;
          data_q     <= shreg_q;
          perr_out_q <= perr_q;
          ferr_out_q <= ~rxs;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (vld_q && rdy) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign vld        = vld_q;
  assign data       = data_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_rx_control.sv
// Directed bench for rx_control: table of complete frames plus hand-written sequences
// for false start, break, overrun and reset in the middle of a frame.
module tb_rx_control;
  import uart_pkg::*;

  localparam int OVS = 16;
  localparam int TPB = 4;          // clk cycles per baud_tick
  localparam int BIT = OVS * TPB;  // clk cycles per bit

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rxd = 1'b1;
  logic       rdy = 1'b0;
  control_t   control = '0;
  logic       vld, parity_err, frame_err, overrun;
  logic [8:0] data;

  rx_control #(.OVERSAMPLE(OVS), .MAX_DATA(9)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .control    (control),
    .baud_tick  (baud_tick),
    .rxd        (rxd),
    .rdy        (rdy),
    .vld        (vld),
    .data       (data),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      baud_tick = (k == TPB - 1);
      k = (k + 1) % TPB;
    end
  end

  int         cap_cnt = 0;
  logic [8:0] cap_data;
  logic       cap_perr, cap_ferr;

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && vld && rdy) begin
        cap_cnt  = cap_cnt + 1;
        cap_data = data;
        cap_perr = parity_err;
        cap_ferr = frame_err;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Changes control after the start bit to prove the frame format was latched.
  task automatic send_frame(input control_t c, input logic [8:0] d, input logic pbit,
                            input logic stopbit);
    control = c;
    rxd = 1'b0;
    wait_clk(BIT);
    control = ~c;
    for (int i = 0; i < int'(c.data_len); i++) begin
      rxd = d[i];
      wait_clk(BIT);
    end
    if (c.parity_en) begin
      rxd = pbit;
      wait_clk(BIT);
    end
    rxd = stopbit;
    wait_clk(BIT);
    if (c.stop2) begin
      rxd = 1'b1;
      wait_clk(BIT);
    end
    rxd = 1'b1;
    wait_clk(BIT);
  endtask

  typedef struct {
    control_t   ctl;
    logic [8:0] din;
    logic       pbit;
    logic       stopbit;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  localparam control_t C8N1 = '{data_len: 4'd8, parity_en: 1'b0, parity_odd: 1'b0, stop2: 1'b0};
  localparam control_t C8E1 = '{data_len: 4'd8, parity_en: 1'b1, parity_odd: 1'b0, stop2: 1'b0};
  localparam control_t C7O2 = '{data_len: 4'd7, parity_en: 1'b1, parity_odd: 1'b1, stop2: 1'b1};
  localparam control_t C5N1 = '{data_len: 4'd5, parity_en: 1'b0, parity_odd: 1'b0, stop2: 1'b0};
  localparam control_t C9N1 = '{data_len: 4'd9, parity_en: 1'b0, parity_odd: 1'b0, stop2: 1'b0};
  localparam control_t C6O1 = '{data_len: 4'd6, parity_en: 1'b1, parity_odd: 1'b1, stop2: 1'b0};

  vec_t vecs[8];

  initial begin
    int base;

    vecs[0] = '{C8N1, 9'h05A, 1'b0, 1'b1, 9'h05A, 1'b0, 1'b0};
    vecs[1] = '{C8E1, 9'h0A5, 1'b1, 1'b1, 9'h0A5, 1'b1, 1'b0};
    vecs[2] = '{C8E1, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vecs[3] = '{C7O2, 9'h041, 1'b1, 1'b1, 9'h041, 1'b0, 1'b0};
    vecs[4] = '{C5N1, 9'h1F5, 1'b0, 1'b1, 9'h015, 1'b0, 1'b0};
    vecs[5] = '{C9N1, 9'h1A5, 1'b0, 1'b1, 9'h1A5, 1'b0, 1'b0};
    vecs[6] = '{C6O1, 9'h02A, 1'b1, 1'b1, 9'h02A, 1'b1, 1'b0};
    vecs[7] = '{C8N1, 9'h05A, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b1};

    // Reset state
    wait_clk(3);
    check("reset vld", 16'(vld), 16'h0);
    check("reset data", 16'(data), 16'h0);
    check("reset parity_err", 16'(parity_err), 16'h0);
    check("reset frame_err", 16'(frame_err), 16'h0);
    check("reset overrun", 16'(overrun), 16'h0);
    reset_n = 1'b1;
    rdy = 1'b1;
    wait_clk(BIT);

    for (int i = 0; i < 8; i++) begin
      base = cap_cnt;
      send_frame(vecs[i].ctl, vecs[i].din, vecs[i].pbit, vecs[i].stopbit);
      check($sformatf("vec%0d words", i), 16'(cap_cnt - base), 16'd1);
      check($sformatf("vec%0d data", i), 16'(cap_data), 16'(vecs[i].exp_data));
      check($sformatf("vec%0d parity_err", i), 16'(cap_perr), 16'(vecs[i].exp_perr));
      check($sformatf("vec%0d frame_err", i), 16'(cap_ferr), 16'(vecs[i].exp_ferr));
      check($sformatf("vec%0d overrun", i), 16'(overrun), 16'h0);
      $display("vec%0d: sent 0x%03h, received 0x%03h perr=%0b ferr=%0b",
               i, vecs[i].din, cap_data, cap_perr, cap_ferr);
    end

    // False start: low for OVERSAMPLE/4 ticks only
    base = cap_cnt;
    control = C8N1;
    rxd = 1'b0;
    wait_clk(OVS / 4 * TPB);
    rxd = 1'b1;
    wait_clk(2 * BIT);
    check("false start words", 16'(cap_cnt - base), 16'd0);
    check("false start state", 16'(dut.state_q), 16'(RX_IDLE));
    send_frame(C8N1, 9'h033, 1'b0, 1'b1);
    check("after false start words", 16'(cap_cnt - base), 16'd1);
    check("after false start data", 16'(cap_data), 16'h033);
    $display("false start: then received 0x%03h", cap_data);

    // Break: 0x00 with low stop bit, line held low for 3 more bit times
    base = cap_cnt;
    control = C8N1;
    rxd = 1'b0;
    wait_clk(10 * BIT);
    wait_clk(3 * BIT);
    check("break words", 16'(cap_cnt - base), 16'd1);
    check("break data", 16'(cap_data), 16'h000);
    check("break frame_err", 16'(cap_ferr), 16'h1);
    rxd = 1'b1;
    wait_clk(2 * BIT);
    check("break release words", 16'(cap_cnt - base), 16'd1);
    send_frame(C8N1, 9'h07E, 1'b0, 1'b1);
    check("after break words", 16'(cap_cnt - base), 16'd2);
    check("after break data", 16'(cap_data), 16'h07E);
    check("after break frame_err", 16'(cap_ferr), 16'h0);
    $display("break: one word ferr=1, then received 0x%03h", cap_data);

    // Overrun: consumer stalled across two frames
    rdy = 1'b0;
    send_frame(C8N1, 9'h011, 1'b0, 1'b1);
    check("ovr first vld", 16'(vld), 16'h1);
    check("ovr first overrun", 16'(overrun), 16'h0);
    send_frame(C8N1, 9'h022, 1'b0, 1'b1);
    check("ovr vld", 16'(vld), 16'h1);
    check("ovr data", 16'(data), 16'h011);
    check("ovr overrun", 16'(overrun), 16'h1);
    rdy = 1'b1;
    wait_clk(1);
    rdy = 1'b0;
    check("ovr drained vld", 16'(vld), 16'h0);
    check("ovr sticky overrun", 16'(overrun), 16'h1);
    $display("overrun: held 0x%03h, overrun=%0b", data, overrun);

    // Reset asserted during data bit 3 of 0xFF
    rdy = 1'b1;
    control = C8N1;
    rxd = 1'b0;
    wait_clk(BIT);
    rxd = 1'b1;
    wait_clk(3 * BIT + BIT / 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset vld", 16'(vld), 16'h0);
    check("async reset data", 16'(data), 16'h0);
    check("async reset overrun", 16'(overrun), 16'h0);
    check("async reset frame_err", 16'(frame_err), 16'h0);
    check("async reset state", 16'(dut.state_q), 16'(RX_IDLE));
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(2 * BIT);
    base = cap_cnt;
    send_frame(C8N1, 9'h03C, 1'b0, 1'b1);
    check("after reset words", 16'(cap_cnt - base), 16'd1);
    check("after reset data", 16'(cap_data), 16'h03C);
    check("after reset errors", 16'({cap_perr, cap_ferr}), 16'h0);
    $display("reset mid-frame: then received 0x%03h", cap_data);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
